seq_divider32: RTL and testbench
================================

Name: seq_divider32

Overview:
- Iterative restoring divider, radix-2, one quotient bit per clock. Companion to the Wallace-tree multiplier datapath: it performs the inverse operation for the same operand width.
- Takes a dividend/divisor pair through a ready/valid input handshake.
- Returns quotient and remainder through a ready/valid output handshake, with a divide-by-zero flag.
- Trial subtraction is two's-complement add (inverted divisor, carry-in 1); the low 32 bits may instantiate cla32bit.

Parameters:
- WIDTH, 32, operand/quotient/remainder width; counter width is clog2(WIDTH)+1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands (high only in IDLE)
- dividend  in  WIDTH  numerator
- divisor  in  WIDTH  denominator
- out_valid  out  1  result valid, held until accepted
- out_ready  in  1  consumer accepts result
- quotient  out  WIDTH  result quotient
- remainder  out  WIDTH  result remainder
- div_by_zero  out  1  divisor was zero for the presented result
- busy  out  1  high in CALC or DONE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0, busy=0.
  - quotient, remainder, div_by_zero, counter and internal partial remainder all 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - in_valid=1 and divisor!=0: latch operands, clear the (WIDTH+1)-bit partial remainder R, count=0, go to CALC.
  - in_valid=1 and divisor==0: go to DONE next edge with quotient=all ones, remainder=dividend, div_by_zero=1.
- CALC, each cycle:
  - R = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifted left.
  - T = R - {0,divisor} on WIDTH+1 bits.
  - If T is non-negative (MSB 0): R=T and Q[0]=1. Otherwise R is unchanged and Q[0]=0.
  - count increments; after WIDTH CALC cycles go to DONE.
  - quotient and remainder outputs load at the CALC-to-DONE transition.
- Latency:
  - Acceptance edge N → out_valid high after edge N+WIDTH+1 (33 cycles at default).
  - Divide-by-zero: out_valid high after edge N+1.
- DONE:
  - out_valid=1; quotient, remainder and div_by_zero are stable while out_valid=1 and out_ready=0.
  - When out_ready=1: go to IDLE next edge, out_valid drops to 0; output data registers keep their value.
- in_ready=0 in CALC and DONE. in_valid there is ignored, not queued, so there is no back-to-back acceptance in the DONE exit cycle.
- Operand inputs may change freely after the acceptance edge.
- rst_n low mid-CALC or mid-DONE aborts immediately to the reset values; no result is emitted.
- Special cases:
  - dividend < divisor: quotient 0, remainder = dividend.
  - divisor=1: quotient = dividend, remainder 0.

Optional Feature:
- Macro SIGNED_DIV_EN.
- Defined:
  - Adds input port is_signed (1 bit), sampled with the operands.
  - When is_signed=1, operands are two's complement. The magnitudes are divided by the unsigned core, then the sign is fixed in DONE entry (no added latency).
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Overflow: 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, div_by_zero=0.
  - Signed divide-by-zero: quotient 0xFFFFFFFF, remainder = dividend.
- Undefined: port absent; all division is unsigned.

Test Plan:
- 100/7, out_ready=1 → out_valid exactly 33 cycles after acceptance; quotient=14, remainder=2, div_by_zero=0; in_ready back to 1 one cycle later.
- 0x12345678/0 → out_valid after 1 cycle; quotient=0xFFFFFFFF, remainder=0x12345678, div_by_zero=1.
- 0xFFFFFFFF/1, then 5/9 → 0xFFFFFFFF rem 0, then 0 rem 5. Hold out_ready=0 for 6 cycles on the first: outputs stable, in_valid pulses ignored, busy=1.
- Accept 1000/3, pulse rst_n low at CALC cycle 10 → all outputs at reset values; a fresh 1000/3 then yields 333 rem 1 with full latency.
- SIGNED_DIV_EN, is_signed=1: −7/2 → 0xFFFFFFFD rem 0xFFFFFFFF; 7/−2 → 0xFFFFFFFD rem 1; 0x80000000/0xFFFFFFFF → 0x80000000 rem 0.
- Back-to-back: in_valid held high continuously across 3 operations → each accepted only in IDLE; exactly 3 results, in order.

Source files
------------

// File: rtl/seq_divider32.sv
// seq_divider32: radix-2 restoring divider, one quotient bit per clock (optional SIGNED_DIV_EN adds is_signed).
// Latency: result valid WIDTH+1 cycles after the acceptance edge; divide-by-zero result valid 1 cycle after.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready, no input queuing.
module seq_divider32 #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef SIGNED_DIV_EN
  input  logic             is_signed,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  // Stored partial remainder is always below the divisor, so its (WIDTH+1)th bit
  // is implicitly zero; only the shifted trial value needs the extra bit.
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic             zero_pend_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic             dbz_q;
`ifdef SIGNED_DIV_EN
  logic             qneg_q;
  logic             rneg_q;
`endif

  logic [WIDTH:0]   r_sh_d;
  logic [WIDTH:0]   trial_d;
  logic [WIDTH-1:0] a_mag_d;
  logic [WIDTH-1:0] b_mag_d;
  logic [WIDTH-1:0] quo_fix_d;
  logic [WIDTH-1:0] rem_fix_d;

  // Operand magnitudes presented to the unsigned core at acceptance
  always_comb begin
    a_mag_d = dividend;
    b_mag_d = divisor;
`ifdef SIGNED_DIV_EN
    if (is_signed && dividend[WIDTH-1]) a_mag_d = -dividend;
    if (is_signed && divisor[WIDTH-1])  b_mag_d = -divisor;
`endif
  end

  // One restoring step: shift in next dividend bit, trial-subtract divisor as add of its complement
  always_comb begin
    r_sh_d  = {rem_q, quo_q[WIDTH-1]};
    trial_d = r_sh_d + {1'b1, ~dvs_q} + {{WIDTH{1'b0}}, 1'b1};
  end

  // Sign correction applied as the result is loaded into the output registers
  always_comb begin
    quo_fix_d = quo_q;
    rem_fix_d = rem_q;
`ifdef SIGNED_DIV_EN
    if (qneg_q) quo_fix_d = -quo_q;
    if (rneg_q) rem_fix_d = -rem_q;
`endif
  end

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      zero_pend_q <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef SIGNED_DIV_EN
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            // A zero divisor keeps the raw dividend so it can be returned as the remainder
            zero_pend_q <= (divisor == '0);
            quo_q       <= (divisor == '0) ? dividend : a_mag_d;
            dvs_q       <= b_mag_d;
            rem_q       <= '0;
            cnt_q       <= '0;
`ifdef SIGNED_DIV_EN
            qneg_q      <= is_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            rneg_q      <= is_signed & dividend[WIDTH-1];
`endif
            state_q     <= CALC;
          end
        end
        CALC: begin
          if (zero_pend_q) begin
            quotient_q  <= '1;
            remainder_q <= quo_q;
            dbz_q       <= 1'b1;
            state_q     <= DONE;
          end else if (cnt_q == CW'(WIDTH)) begin
            quotient_q  <= quo_fix_d;
            remainder_q <= rem_fix_d;
            dbz_q       <= 1'b0;
            state_q     <= DONE;
          end else begin
            quo_q <= {quo_q[WIDTH-2:0], ~trial_d[WIDTH]};
            rem_q <= trial_d[WIDTH] ? r_sh_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider32.sv
// tb_seq_divider32: directed and random operand pairs against an arithmetic reference.
// Exercises latency, hold under backpressure, mid-operation reset and continuous in_valid.
// Define SIGNED_DIV_EN to include the signed cases.
module tb_seq_divider32;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        is_sig;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  logic [31:0] eq_q[$];
  logic [31:0] er_q[$];
  logic        ez_q[$];
  logic [31:0] ba[3];
  logic [31:0] bb[3];

  seq_divider32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
`ifdef SIGNED_DIV_EN
    .is_signed  (is_sig),
`endif
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer division with the documented special cases
  task automatic ref_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output logic [31:0] q, output logic [31:0] r, output logic z);
    int sa, sb;
    sa = a;
    sb = b;
    z  = (b == 32'd0);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF;
      r = a;
    end else if (!s) begin
      q = a / b;
      r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'd0;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s, input int hold);
    logic [31:0] eq, er;
    logic        ez;
    logic        s_eff;
    int          lat;
`ifdef SIGNED_DIV_EN
    s_eff = s;
`else
    s_eff = 1'b0;
`endif
    ref_div(a, b, s_eff, eq, er, ez);
    lat = 0;
    while (!in_ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("idle_in_ready", in_ready, 1);
    dividend  = a;
    divisor   = b;
    is_sig    = s_eff;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    dividend = $urandom;
    divisor  = $urandom;
    is_sig   = 1'($urandom_range(0, 1));
    chk("accept_in_ready", in_ready, 0);
    chk("accept_busy", busy, 1);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, (b == 32'd0) ? 32'd1 : 32'd33);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, ez);
    for (int i = 0; i < hold; i++) begin
      in_valid = i[0];
      dividend = $urandom;
      divisor  = $urandom;
      @(posedge clk); #1;
      chk("hold_out_valid", out_valid, 1);
      chk("hold_busy", busy, 1);
      chk("hold_in_ready", in_ready, 0);
      chk("hold_quotient", quotient, eq);
      chk("hold_remainder", remainder, er);
      chk("hold_dbz", div_by_zero, ez);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("exit_out_valid", out_valid, 0);
    chk("exit_in_ready", in_ready, 1);
    chk("exit_busy", busy, 0);
    chk("keep_quotient", quotient, eq);
    chk("keep_remainder", remainder, er);
    out_ready = 1'b0;
  endtask

  initial begin
    int          acc, got;
    logic [31:0] a, b, tq, tr;
    logic        tz, s;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    is_sig    = 1'b0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    do_op(32'd100, 32'd7, 1'b0, 0);
    do_op(32'h1234_5678, 32'd0, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 6);
    do_op(32'd5, 32'd9, 1'b0, 0);

    // Reset in the middle of a calculation
    dividend = 32'd1000;
    divisor  = 32'd3;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
    end
    chk("midcalc_busy", busy, 1);
    rst_n = 1'b0;
    #2;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_quotient", quotient, 0);
    chk("abort_remainder", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_op(32'd1000, 32'd3, 1'b0, 0);

`ifdef SIGNED_DIV_EN
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 2);
    do_op(32'hFFFF_FFF9, 32'd0, 1'b1, 0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0, 0);
`endif

    // in_valid held high across three operations
    ba[0] = 32'd20;    bb[0] = 32'd3;
    ba[1] = 32'd4321;  bb[1] = 32'd0;
    ba[2] = 32'd77777; bb[2] = 32'd9;
    acc = 0;
    got = 0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 400 && got < 3; cyc++) begin
      if (out_valid) begin
        chk("b2b_in_ready_in_done", in_ready, 0);
        if (eq_q.size() > 0) begin
          chk("b2b_quotient", quotient, eq_q.pop_front());
          chk("b2b_remainder", remainder, er_q.pop_front());
          chk("b2b_dbz", div_by_zero, ez_q.pop_front());
        end
        got++;
      end
      if (in_ready) begin
        if (acc < 3) begin
          dividend = ba[acc];
          divisor  = bb[acc];
          in_valid = 1'b1;
          ref_div(ba[acc], bb[acc], 1'b0, tq, tr, tz);
          eq_q.push_back(tq);
          er_q.push_back(tr);
          ez_q.push_back(tz);
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) got++;
    end
    chk("b2b_accepted", acc, 3);
    chk("b2b_results", got, 3);
    out_ready = 1'b0;

    // Random operands, including zero, unit and near-equal divisors
    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      case ($urandom_range(0, 5))
        0:       b = 32'd0;
        1:       b = 32'd1;
        2:       b = a;
        3:       b = a + 32'd1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
`ifdef SIGNED_DIV_EN
      s = 1'($urandom_range(0, 1));
`else
      s = 1'b0;
`endif
      do_op(a, b, s, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
